// File: rtl/calc_entry_sequencer.sv
// Entry sequencer for the calculator: turns debounced enter/undo levels into
// single-cycle load/clear strobes for the operand A, operand B and opcode
// registers, and exposes the current entry step as the display select.
module calc_entry_sequencer #(
  parameter int unsigned OPW            = 2,
  parameter int unsigned NUM_OPS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enter,
  input  logic           undo,
  input  logic [OPW-1:0] opcode_in,
  output logic           load_op1,
  output logic           load_op2,
  output logic           load_opcode,
  output logic           clear_regs,
  output logic           op_error,
  output logic [1:0]     state,
  output logic           result_valid
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_OPCODE = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter_dly_q, enter_dly_d;
  logic          undo_dly_q, undo_dly_d;
  logic          enter_p, undo_p;

  // Rising-edge detect; delay flops reset high so a held button gives no pulse
  assign enter_p     = enter & ~enter_dly_q;
  assign undo_p      = undo & ~undo_dly_q;
  assign enter_dly_d = enter;
  assign undo_dly_d  = undo;

  // State, idle counter and edge-detect registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OP1;
      cnt_q       <= '0;
      enter_dly_q <= 1'b1;
      undo_dly_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enter_dly_q <= enter_dly_d;
      undo_dly_q  <= undo_dly_d;
    end
  end

  // Next state, idle counter and Mealy strobes; undo beats enter beats timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    load_op1    = 1'b0;
    load_op2    = 1'b0;
    load_opcode = 1'b0;
    clear_regs  = 1'b0;
    op_error    = 1'b0;
    if (!reset) begin
      if (undo_p) begin
        case (state_q)
          S_OP2:    state_d = S_OP1;
          S_OPCODE: state_d = S_OP2;
          S_RESULT: state_d = S_OPCODE;
          default:  state_d = S_OP1;
        endcase
      end else if (enter_p) begin
        case (state_q)
          S_OP1: begin
            load_op1 = 1'b1;
            state_d  = S_OP2;
          end
          S_OP2: begin
            load_op2 = 1'b1;
            state_d  = S_OPCODE;
          end
          S_OPCODE: begin
            if (32'(opcode_in) < NUM_OPS) begin
              load_opcode = 1'b1;
              state_d     = S_RESULT;
            end else begin
              op_error = 1'b1;
            end
          end
          default: begin
            clear_regs = 1'b1;
            state_d    = S_OP1;
          end
        endcase
      end else if (state_q == S_RESULT) begin
        if (cnt_q == CNT_LAST) begin
          clear_regs = 1'b1;
          state_d    = S_OP1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign state        = state_q;
  assign result_valid = (state_q == S_RESULT);

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer (NUM_OPS=3, TIMEOUT_CYCLES=8).
// Each step queues the expected strobes/state for the cycle it drives and
// checks them against the DUT just before the next rising edge.
module tb_calc_entry_sequencer;

  localparam int unsigned OPW = 2;

  // Strobe vector order: {load_op1, load_op2, load_opcode, clear_regs, op_error}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] L1 = 5'b10000;
  localparam logic [4:0] L2 = 5'b01000;
  localparam logic [4:0] LO = 5'b00100;
  localparam logic [4:0] CL = 5'b00010;
  localparam logic [4:0] ER = 5'b00001;

  typedef struct {
    logic [4:0] strb;
    logic [1:0] st;
    string      tag;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           enter;
  logic           undo;
  logic [OPW-1:0] opcode_in;
  logic           load_op1, load_op2, load_opcode, clear_regs, op_error;
  logic [1:0]     state;
  logic           result_valid;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  calc_entry_sequencer #(
    .OPW(OPW),
    .NUM_OPS(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enter(enter),
    .undo(undo),
    .opcode_in(opcode_in),
    .load_op1(load_op1),
    .load_op2(load_op2),
    .load_opcode(load_opcode),
    .clear_regs(clear_regs),
    .op_error(op_error),
    .state(state),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // One cycle: drive at negedge, queue expectation, check 2 ns before posedge
  task automatic step(input logic r, input logic e, input logic u, input logic [OPW-1:0] op,
                      input logic [1:0] exp_st, input logic [4:0] exp_strb, input string tag);
    exp_t x;
    logic [4:0] obs;
    int ones;
    @(negedge clk);
    reset = r; enter = e; undo = u; opcode_in = op;
    x.strb = exp_strb; x.st = exp_st; x.tag = tag;
    sb.push_back(x);
    #3;
    x   = sb.pop_front();
    obs = {load_op1, load_op2, load_opcode, clear_regs, op_error};
    checks++;
    assert (obs === x.strb) else begin
      errors++;
      $error("FAIL %s strobes observed=%b expected=%b", x.tag, obs, x.strb);
    end
    checks++;
    assert (state === x.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", x.tag, state, x.st);
    end
    checks++;
    assert (result_valid === (x.st == 2'd3)) else begin
      errors++;
      $error("FAIL %s result_valid observed=%b expected=%b", x.tag, result_valid, (x.st == 2'd3));
    end
    ones = int'(load_op1) + int'(load_op2) + int'(load_opcode) + int'(clear_regs);
    checks++;
    assert (ones <= 1) else begin
      errors++;
      $error("FAIL %s onehot observed=%0d expected<=1", x.tag, ones);
    end
  endtask

  task automatic idles(input int n, input logic [1:0] st, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, st, NO, tag);
  endtask

  // From S_OP1 with buttons released: A, B, then a legal opcode into S_RESULT
  task automatic go_result(input logic [OPW-1:0] op, input string tag);
    step(1'b0, 1'b1, 1'b0, op, 2'd0, L1, tag);
    step(1'b0, 1'b0, 1'b0, op, 2'd1, NO, tag);
    step(1'b0, 1'b1, 1'b0, op, 2'd1, L2, tag);
    step(1'b0, 1'b0, 1'b0, op, 2'd2, NO, tag);
    step(1'b0, 1'b1, 1'b0, op, 2'd2, LO, tag);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; undo = 1'b0; opcode_in = '0;
    repeat (2) @(posedge clk);

    // Reset state, then the basic A/B/opcode/result walk
    step(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, NO, "reset");
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, NO, "post_reset");
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, L1, "walk_a");
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'd1, NO, "walk_gap");
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd1, L2, "walk_b");
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'd2, NO, "walk_gap");
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd2, LO, "walk_op");
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'd3, NO, "walk_result");
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd3, CL, "walk_clear");
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, NO, "walk_done");

    // Enter held for 10 cycles gives a single load_op1
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, L1, "hold_first");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, NO, "hold_rest");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, NO, "hold_release");
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd1, NO, "hold_undo");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "hold_back");

    // Enter held across reset release: no strobe until released and re-pressed
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, L1, "rst_hold_pre");
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, NO, "rst_hold_reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, NO, "rst_hold_held");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "rst_hold_release");
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, L1, "rst_hold_press");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, NO, "rst_hold_gap");

    // Opcode 3 is illegal with NUM_OPS=3, opcode 0 is legal
    step(1'b0, 1'b1, 1'b0, 2'd3, 2'd1, L2, "opc_b");
    step(1'b0, 1'b0, 1'b0, 2'd3, 2'd2, NO, "opc_gap");
    step(1'b0, 1'b1, 1'b0, 2'd3, 2'd2, ER, "opc_illegal");
    step(1'b0, 1'b0, 1'b0, 2'd3, 2'd2, NO, "opc_stay");
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, LO, "opc_legal");

    // Undo walk 3,2,1,0,0 with no strobes
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd3, NO, "undo_3");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd2, NO, "undo_gap");
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd2, NO, "undo_2");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, NO, "undo_gap");
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd1, NO, "undo_1");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "undo_gap");
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, NO, "undo_0");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "undo_stay");

    // Same-cycle enter and undo in S_OP2: undo wins, no load
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, L1, "both_a");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, NO, "both_gap");
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, NO, "both_press");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "both_after");

    // Idle timeout fires on the 8th idle cycle in S_RESULT
    go_result(2'd1, "to_setup");
    idles(7, 2'd3, "to_idle");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd3, CL, "to_fire");
    idles(2, 2'd0, "to_after");

    // Enter on the 8th idle cycle: exactly one clear
    go_result(2'd2, "to_en_setup");
    idles(7, 2'd3, "to_en_idle");
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, CL, "to_en_fire");
    idles(2, 2'd0, "to_en_after");

    // Undo at idle cycle 5, then the count restarts from zero on re-entry
    go_result(2'd0, "to_un_setup");
    idles(4, 2'd3, "to_un_idle");
    step(1'b0, 1'b0, 1'b1, 2'd0, 2'd3, NO, "to_un_undo");
    idles(10, 2'd2, "to_un_opcode");
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, LO, "to_un_reenter");
    idles(7, 2'd3, "to_un_idle2");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd3, CL, "to_un_fire");
    idles(1, 2'd0, "to_un_after");

    // Reset in S_OPCODE together with enter: no load, back to S_OP1
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, L1, "rst_mid_a");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, NO, "rst_mid_gap");
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, L2, "rst_mid_b");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd2, NO, "rst_mid_gap");
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'd2, NO, "rst_mid_reset");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, NO, "rst_mid_after");

    // Reset in S_RESULT mid-count, then a full 8-cycle timeout again
    go_result(2'd1, "rst_cnt_setup");
    idles(5, 2'd3, "rst_cnt_idle");
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd3, NO, "rst_cnt_reset");
    idles(1, 2'd0, "rst_cnt_after");
    go_result(2'd1, "rst_cnt_setup2");
    idles(7, 2'd3, "rst_cnt_idle2");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd3, CL, "rst_cnt_fire");
    idles(1, 2'd0, "rst_cnt_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
